bz_beat_timer: RTL and testbench

BZ_BEAT_TIMER -- requirements
Module: bz_beat_timer

---
 rtl/bz_pkg.sv | 15 +
 rtl/bz_beat_timer.sv | 146 ++++++++++++++
 tb/tb_bz_beat_timer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bz_pkg.sv
// Shared definitions for the buzzer beat timer: mode encodings and FSM states.
package bz_pkg;

    // Run modes as presented on the mode input. Codes 10 and 11 are both continuous.
    localparam logic [1:0] BZ_MODE_SINGLE = 2'b00;
    localparam logic [1:0] BZ_MODE_BURST  = 2'b01;
    localparam logic [1:0] BZ_MODE_CONT   = 2'b10;

    // Controller states.
    typedef enum logic {
        BZ_IDLE = 1'b0,
        BZ_RUN  = 1'b1
    } bz_state_t;

endpackage

// File: rtl/bz_beat_timer.sv
// Buzzer beat timer: counts beats of (period+1) enabled cycles, drives a gate
// for the first gate_len cycles of each beat, and ends after one beat, a burst
// of beat_num beats, or only on stop. All outputs come straight from flops.
module bz_beat_timer
    import bz_pkg::*;
#(
    parameter int CNT_W = 28,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] gate_len,
    input  logic [IDX_W-1:0] beat_num,
    output logic             busy,
    output logic             beat_pulse,
    output logic             done,
    output logic             gate,
    output logic [IDX_W-1:0] beat_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    bz_state_t        r_state;
    bz_state_t        w_state_nxt;
    logic [1:0]       r_mode;
    logic [IDX_W-1:0] r_beat_num;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_q;
    logic [CNT_W-1:0] r_gate_len_q;
    logic [IDX_W-1:0] r_beat_idx;
    logic             r_busy;
    logic             r_pulse;
    logic             r_done;
    logic             r_gate;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_gate_len_nxt;
    logic [IDX_W-1:0] w_beat_idx_nxt;
    logic [IDX_W-1:0] w_beat_idx_inc;
    logic [IDX_W-1:0] w_beat_target;
    logic             w_launch;
    logic             w_advance;
    logic             w_tc;
    logic             w_last;

    // A run starts only from IDLE and only when not cancelled by a simultaneous stop.
    assign w_launch       = (r_state == BZ_IDLE) && start && !stop;
    // The counter moves only in an enabled, non-aborted RUN cycle.
    assign w_advance      = (r_state == BZ_RUN) && en && !stop;
    assign w_tc           = w_advance && (r_cnt == r_period_q);
    assign w_beat_idx_inc = r_beat_idx + IDX_ONE;
    // A burst of zero beats behaves as a burst of one.
    assign w_beat_target  = (r_beat_num == '0) ? IDX_ONE : r_beat_num;

    // Decide whether the beat completing this cycle is the last one of the run.
    always_comb begin
        case (r_mode)
            BZ_MODE_SINGLE: w_last = w_tc && (w_beat_idx_inc == IDX_ONE);
            BZ_MODE_BURST:  w_last = w_tc && (w_beat_idx_inc == w_beat_target);
            default:        w_last = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) r_state <= BZ_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: launch from IDLE, leave RUN on stop or on the final beat.
    always_comb begin
        // NOTE: default first so no path through the block leaves it unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            BZ_IDLE: if (w_launch)        w_state_nxt = BZ_RUN;
            BZ_RUN:  if (stop || w_last)  w_state_nxt = BZ_IDLE;
            default:                      w_state_nxt = BZ_IDLE;
        endcase
    end

    // Output/datapath logic: next values for counter, beat index and tempo registers.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_beat_idx_nxt = r_beat_idx;
        w_period_nxt   = r_period_q;
        w_gate_len_nxt = r_gate_len_q;
        if (w_launch) begin
            w_cnt_nxt      = '0;
            w_beat_idx_nxt = '0;
            w_period_nxt   = period;
            w_gate_len_nxt = gate_len;
        end else if (w_tc) begin
            // Beat boundary: tempo and gate length may change here and only here.
            w_cnt_nxt      = '0;
            w_beat_idx_nxt = w_beat_idx_inc;
            w_period_nxt   = period;
            w_gate_len_nxt = gate_len;
        end else if (w_advance) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Datapath and output registers; gate is computed from next-cycle values so it lines up with cnt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode       <= BZ_MODE_SINGLE;
            r_beat_num   <= '0;
            r_cnt        <= '0;
            r_period_q   <= '0;
            r_gate_len_q <= '0;
            r_beat_idx   <= '0;
            r_busy       <= 1'b0;
            r_pulse      <= 1'b0;
            r_done       <= 1'b0;
            r_gate       <= 1'b0;
        end else begin
            if (w_launch) begin
                r_mode     <= mode;
                r_beat_num <= beat_num;
            end
            r_cnt        <= w_cnt_nxt;
            r_period_q   <= w_period_nxt;
            r_gate_len_q <= w_gate_len_nxt;
            r_beat_idx   <= w_beat_idx_nxt;
            r_busy       <= (w_state_nxt == BZ_RUN);
            r_pulse      <= w_tc;
            r_done       <= w_last;
            r_gate       <= (w_state_nxt == BZ_RUN) && (w_cnt_nxt < w_gate_len_nxt);
        end
    end

    assign busy       = r_busy;
    assign beat_pulse = r_pulse;
    assign done       = r_done;
    assign gate       = r_gate;
    assign beat_idx   = r_beat_idx;

endmodule

// File: tb/tb_bz_beat_timer.sv
// Self-checking bench for bz_beat_timer: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// beat-level behavioural model.
module tb_bz_beat_timer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic        en;
    logic [1:0]  mode;
    logic [27:0] period;
    logic [27:0] gate_len;
    logic [7:0]  beat_num;
    logic        busy;
    logic        beat_pulse;
    logic        done;
    logic        gate;
    logic [7:0]  beat_idx;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 0;

    // Behavioural model: run flag, position inside the beat, beat length, gate length,
    // beats required for the run (0 = unlimited), beats done so far.
    bit m_run;
    int m_pos, m_len, m_gl, m_target, m_total, m_count;
    bit e_busy, e_pulse, e_done, e_gate;
    int e_idx;

    bz_beat_timer #(.CNT_W(28), .IDX_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .en(en),
        .mode(mode), .period(period), .gate_len(gate_len), .beat_num(beat_num),
        .busy(busy), .beat_pulse(beat_pulse), .done(done), .gate(gate),
        .beat_idx(beat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_len = 0; m_gl = 0; m_target = 0; m_total = 0; m_count = 0;
        e_busy = 0; e_pulse = 0; e_done = 0; e_gate = 0; e_idx = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        e_pulse = 0;
        e_done  = 0;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_pos = 0; m_total = 0; m_count = 0;
                m_len = int'(period); m_gl = int'(gate_len);
                if (mode == 2'b00)      m_target = 1;
                else if (mode == 2'b01) m_target = (beat_num == 0) ? 1 : int'(beat_num);
                else                    m_target = 0;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (en) begin
            if (m_pos == m_len) begin
                e_pulse = 1;
                m_total++;
                m_count = (m_count + 1) % 256;
                m_pos = 0; m_len = int'(period); m_gl = int'(gate_len);
                if (m_target != 0 && m_total == m_target) begin
                    m_run  = 0;
                    e_done = 1;
                end
            end else begin
                m_pos++;
            end
        end
        e_busy = m_run;
        e_gate = m_run && (m_pos < m_gl);
        e_idx  = m_count;
    endtask

    // One clock: model follows the driven inputs, then wait to just past the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model, on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("beat_pulse", 32'(beat_pulse), 32'(e_pulse));
            check("done", 32'(done), 32'(e_done));
            check("gate", 32'(gate), 32'(e_gate));
            check("beat_idx", 32'(beat_idx), 32'(e_idx));
        end
    end

    initial begin
        int np;
        int pcyc[4];
        int gcnt;
        rstn = 0; start = 0; stop = 0; en = 1; mode = 2'b00;
        period = '0; gate_len = '0; beat_num = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_gate", 32'(gate), 32'd0);
        check("reset_idx", 32'(beat_idx), 32'd0);
        rstn = 1;
        cmp_on = 1;
        tick();

        // Single beat, period 3: busy from T1, pulse+done at T5 with busy low.
        mode = 2'b00; period = 28'd3; gate_len = 28'd2; start = 1;
        tick();
        check("single_busy_t1", 32'(busy), 32'd1);
        start = 0;
        tick(); tick(); tick();
        check("single_nopulse_t4", 32'(beat_pulse), 32'd0);
        tick();
        check("single_pulse_t5", 32'(beat_pulse), 32'd1);
        check("single_done_t5", 32'(done), 32'd1);
        check("single_busy_t5", 32'(busy), 32'd0);
        tick();

        // Burst of 3, period 4, gate 2.
        mode = 2'b01; beat_num = 8'd3; period = 28'd4; gate_len = 28'd2; start = 1;
        tick();
        start = 0; np = 0; gcnt = 0;
        for (int c = 1; c <= 16; c++) begin
            if (beat_pulse && np < 4) begin pcyc[np] = c; np++; end
            if (c <= 15 && gate) gcnt++;
            if (c < 16) tick();
        end
        check("burst_pulses", 32'(np), 32'd3);
        check("burst_first_pulse", 32'(pcyc[0]), 32'd6);
        check("burst_gate_cycles", 32'(gcnt), 32'd6);
        check("burst_done", 32'(done), 32'd1);
        check("burst_idx", 32'(beat_idx), 32'd3);
        tick();

        // Continuous, period 9 changed to 4 mid-beat, then stop.
        mode = 2'b10; period = 28'd9; gate_len = 28'd3; start = 1;
        tick();
        start = 0; np = 0;
        for (int c = 1; c <= 21; c++) begin
            if (beat_pulse && np < 4) begin pcyc[np] = c; np++; end
            if (c == 3) period = 28'd4;
            tick();
        end
        check("cont_pulse0", 32'(pcyc[0]), 32'd11);
        check("cont_pulse1", 32'(pcyc[1]), 32'd16);
        check("cont_pulse2", 32'(pcyc[2]), 32'd21);
        stop = 1;
        tick();
        stop = 0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_gate", 32'(gate), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        tick();

        // Enable low for 7 cycles mid-beat delays the pulse by 7.
        mode = 2'b00; period = 28'd5; gate_len = 28'd2; start = 1;
        tick();
        start = 0; np = 0;
        for (int c = 1; c <= 14; c++) begin
            en = !(c >= 2 && c <= 8);
            if (beat_pulse && np < 4) begin pcyc[np] = c; np++; end
            if (c == 9) begin
                check("stall_gate_frozen", 32'(gate), 32'd1);
                check("stall_idx_frozen", 32'(beat_idx), 32'd0);
            end
            if (c < 14) tick();
        end
        check("stall_pulse_cycle", 32'(beat_pulse), 32'd1);
        check("stall_pulse_count", 32'(np), 32'd1);
        en = 1;
        tick();

        // period 0, burst of 0 beats; a start during RUN is ignored.
        mode = 2'b01; period = '0; beat_num = '0; gate_len = 28'd1; start = 1;
        tick();
        check("p0_busy_t1", 32'(busy), 32'd1);
        tick();
        start = 0;
        check("p0_pulse_t2", 32'(beat_pulse), 32'd1);
        check("p0_done_t2", 32'(done), 32'd1);
        tick();
        check("p0_idle_t3", 32'(busy), 32'd0);

        // Reset mid-run, then start right after release.
        mode = 2'b10; period = 28'd1; gate_len = 28'd1; start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        rstn = 0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_gate", 32'(gate), 32'd0);
        check("arst_idx", 32'(beat_idx), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rstn = 1; mode = 2'b00; period = 28'd2; start = 1;
        tick();
        check("post_reset_start", 32'(busy), 32'd1);
        start = 0;
        repeat (4) tick();

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom_range(499) != 0);
            start    = ($urandom_range(7) == 0);
            stop     = ($urandom_range(29) == 0);
            en       = ($urandom_range(99) < 85);
            mode     = 2'($urandom_range(3));
            period   = 28'($urandom_range(6));
            gate_len = 28'($urandom_range(8));
            beat_num = 8'($urandom_range(4));
            tick();
        end
        rstn = 1; start = 0; stop = 0;
        tick();
        cmp_on = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
